// File: rtl/rom_program_loader.sv
// Framed byte-stream loader for instruction memory: writes {opcode, address}
// words from address 0 upward and holds the CPU until a frame checks out.
module rom_program_loader #(
    parameter int         ADDR_BITS = 8,
    parameter int         DATA_BITS = 8,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   mem_we,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic [2*DATA_BITS-1:0] mem_wdata,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   error
);

    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN,
        S_OPC,
        S_ADR,
        S_WR,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_BITS-1:0]   len_reg, len_next;
    logic [ADDR_BITS-1:0]   word_cnt_reg, word_cnt_next;
    logic [7:0]             chk_reg, chk_next;
    logic [DATA_BITS-1:0]   opc_reg, opc_next;

    logic                   in_ready_reg, in_ready_next;
    logic                   mem_we_reg, mem_we_next;
    logic [ADDR_BITS-1:0]   mem_addr_reg, mem_addr_next;
    logic [2*DATA_BITS-1:0] mem_wdata_reg, mem_wdata_next;
    logic                   cpu_hold_reg, cpu_hold_next;
    logic                   done_reg, done_next;
    logic                   error_reg, error_next;

    logic                   accept;

    assign accept = in_valid && in_ready_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= S_SYNC;
            len_reg       <= '0;
            word_cnt_reg  <= '0;
            chk_reg       <= '0;
            opc_reg       <= '0;
            // The loader is ready as soon as reset is released.
            in_ready_reg  <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            cpu_hold_reg  <= 1'b1;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            word_cnt_reg  <= word_cnt_next;
            chk_reg       <= chk_next;
            opc_reg       <= opc_next;
            in_ready_reg  <= in_ready_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            cpu_hold_reg  <= cpu_hold_next;
            done_reg      <= done_next;
            error_reg     <= error_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        word_cnt_next  = word_cnt_reg;
        chk_next       = chk_reg;
        opc_next       = opc_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;

        case (state_reg)
            S_SYNC: begin
                if (accept && in_data == SYNC_BYTE) state_next = S_LEN;
            end
            S_LEN: begin
                if (accept) begin
                    if (in_data == 8'h00) begin
                        state_next = S_ERR;
                    end else begin
                        len_next      = ADDR_BITS'(in_data);
                        chk_next      = in_data;
                        word_cnt_next = '0;
                        state_next    = S_OPC;
                    end
                end
            end
            S_OPC: begin
                if (accept) begin
                    opc_next   = DATA_BITS'(in_data);
                    chk_next   = chk_reg ^ in_data;
                    state_next = S_ADR;
                end
            end
            S_ADR: begin
                // Word and address are staged here so they appear with the WR strobe.
                if (accept) begin
                    chk_next       = chk_reg ^ in_data;
                    mem_addr_next  = word_cnt_reg;
                    mem_wdata_next = {opc_reg, DATA_BITS'(in_data)};
                    state_next     = S_WR;
                end
            end
            S_WR: begin
                if (word_cnt_reg == len_reg - ADDR_BITS'(1)) begin
                    state_next = S_CHK;
                end else begin
                    word_cnt_next = word_cnt_reg + ADDR_BITS'(1);
                    state_next    = S_OPC;
                end
            end
            S_CHK: begin
                if (accept) state_next = (in_data == chk_reg) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: begin
                if (accept && in_data == SYNC_BYTE) state_next = S_LEN;
            end
            default: state_next = S_SYNC;
        endcase

        // Outputs are registered copies of the next-state decode, so leaving
        // DONE for LEN re-holds the CPU on the very edge that accepts SYNC.
        in_ready_next = (state_next != S_WR);
        mem_we_next   = (state_next == S_WR);
        cpu_hold_next = (state_next != S_DONE);
        done_next     = (state_next == S_DONE);
        error_next    = (state_next == S_ERR);
    end

    assign in_ready  = in_ready_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign cpu_hold  = cpu_hold_reg;
    assign done      = done_reg;
    assign error     = error_reg;

endmodule

// File: tb/tb_rom_program_loader.sv
// Directed scenarios for rom_program_loader: good/bad frames, in-frame sync
// bytes, stalls, mid-frame reset and LEN=0 after a completed load.
module tb_rom_program_loader;

    logic        clock;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [23:0] wr_q[$];
    logic [7:0]  frame_q[$];
    int          ready_low_cnt = 0;
    int          handshake_bad = 0;

    rom_program_loader dut (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Write and ready observer, sampled mid-cycle.
    always @(negedge clock) begin
        if (mem_we) begin
            wr_q.push_back({mem_addr, mem_wdata});
            $display("write addr=%02h data=%04h", mem_addr, mem_wdata);
        end
        if (!in_ready) ready_low_cnt++;
        if (in_ready == mem_we) handshake_bad++;
    end

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int waited;
        if (stall) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clock);
                in_valid = 1'b0;
                in_data  = $urandom_range(0, 255);
            end
        end
        @(negedge clock);
        in_data  = b;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: byte %02h in_ready=%b required 1", b, in_ready);
        end
        @(posedge clock);
        $display("byte %02h accepted", b);
    endtask

    task automatic send_frame(input bit stall);
        foreach (frame_q[i]) send_byte(frame_q[i], stall);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic check_writes(input string name, input logic [23:0] exp[$]);
        logic [23:0] got;
        checks++;
        if (wr_q.size() !== exp.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d writes, required %0d", name, wr_q.size(), exp.size());
        end
        foreach (exp[i]) begin
            got = (i < wr_q.size()) ? wr_q[i] : 24'hxxxxxx;
            checks++;
            if (got !== exp[i]) begin
                errors++;
                $display("FAIL %s_write%0d: got %06h, required %06h", name, i, got, exp[i]);
            end
        end
    endtask

    task automatic check_flags(input string name, input logic d, input logic e, input logic h);
        checks++;
        if ({done, error, cpu_hold} !== {d, e, h}) begin
            errors++;
            $display("FAIL %s_flags: done/error/hold=%b%b%b, required %b%b%b",
                     name, done, error, cpu_hold, d, e, h);
        end
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clock);
        checks++;
        if ({mem_we, mem_addr, mem_wdata, cpu_hold, done, error} !== {1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: we=%b addr=%02h data=%04h hold=%b done=%b err=%b, required 0 00 0000 1 0 0",
                     mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        wr_q.delete();
    endtask

    task automatic test_good_frame;
        logic [23:0] exp[$];
        frame_q = '{8'hA5, 8'h02, 8'h10, 8'h05, 8'h20, 8'h06, 8'h31};
        exp = '{24'h001005, 24'h012006};
        wr_q.delete();
        send_frame(1'b0);
        check_writes("good_frame", exp);
        check_flags("good_frame", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_bad_checksum;
        logic [23:0] exp[$];
        frame_q = '{8'hA5, 8'h02, 8'h10, 8'h05, 8'h20, 8'h06, 8'h30};
        exp = '{24'h001005, 24'h012006};
        wr_q.delete();
        send_frame(1'b0);
        check_writes("bad_chk", exp);
        check_flags("bad_chk", 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_garbage_and_sync_data;
        logic [23:0] exp[$];
        frame_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h01};
        exp = '{24'h00A5A5};
        wr_q.delete();
        send_frame(1'b0);
        check_writes("sync_data", exp);
        check_flags("sync_data", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_len_zero_after_done;
        logic [23:0] exp[$];
        wr_q.delete();
        send_byte(8'hA5, 1'b0);
        @(negedge clock);
        in_valid = 1'b0;
        check_flags("rehold", 1'b0, 1'b0, 1'b1);
        send_byte(8'h00, 1'b0);
        @(negedge clock);
        in_valid = 1'b0;
        check_flags("len_zero", 1'b0, 1'b1, 1'b1);
        check_writes("len_zero", exp);
    endtask

    task automatic test_stall;
        logic [23:0] exp[$];
        frame_q = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h04};
        exp = '{24'h000102, 24'h010304, 24'h020506};
        wr_q.delete();
        ready_low_cnt = 0;
        handshake_bad = 0;
        send_frame(1'b1);
        check_writes("stall", exp);
        check_flags("stall", 1'b1, 1'b0, 1'b0);
        checks++;
        if (ready_low_cnt !== 3 || handshake_bad !== 0) begin
            errors++;
            $display("FAIL stall_ready: low cycles=%0d misaligned=%0d, required 3 and 0",
                     ready_low_cnt, handshake_bad);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [23:0] exp[$];
        frame_q = '{8'hA5, 8'h04, 8'h11, 8'h22, 8'h33};
        exp = '{24'h001122};
        wr_q.delete();
        send_frame(1'b0);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({mem_we, mem_addr, mem_wdata, cpu_hold, done, error, in_ready} !== {1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL midreset_outputs: we=%b addr=%02h data=%04h hold=%b done=%b err=%b rdy=%b, required 0 00 0000 1 0 0 1",
                     mem_we, mem_addr, mem_wdata, cpu_hold, done, error, in_ready);
        end
        check_writes("midreset", exp);
        reset = 1'b0;
        frame_q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h27};
        exp = '{24'h001234};
        wr_q.delete();
        send_frame(1'b0);
        check_writes("after_reset", exp);
        check_flags("after_reset", 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_bad_checksum;
        test_garbage_and_sync_data;
        test_len_zero_after_done;
        test_stall;
        test_reset_mid_frame;
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
